axi_burst_slave: RTL and testbench
==================================

# axi_burst_slave
- Parametrised AXI4 slave bridging one AXI master to a simple asynchronous-read, synchronous-write word memory.
- Full read and write burst support: INCR, FIXED and WRAP bursts, AxSIZE narrow transfers, byte strobes, error responses.
- Sits between the interconnect and on-chip RAM/peripheral models.
## Interface
- AXI_ADDR_WIDTH, 64: address width of AXI and memory ports.
- AXI_DATA_WIDTH, 32: data width; power of two, 32..512.
- clk  in  1  clock, all logic on rising edge.
- arst  in  1  asynchronous active-high reset.
- o_addr  out  AXI_ADDR_WIDTH  current beat byte address to memory.
- o_rd_en  out  1  read beat active (equals R_VALID).
- i_rd_data  in  AXI_DATA_WIDTH  memory read data, combinational from o_addr.
- o_wr_en  out  1  write beat: W_VALID & W_READY & no error.
- o_wr_data  out  AXI_DATA_WIDTH  write data (W_DATA).
- o_wr_strb  out  AXI_DATA_WIDTH/8  byte enables (W_STRB).
- AR_READY out 1; AR_VALID in 1; AR_ADDR in AXI_ADDR_WIDTH; AR_LEN in 8; AR_SIZE in 3; AR_BURST in 2: read address channel.
- R_DATA  out  AXI_DATA_WIDTH  i_rd_data, or zero on error burst.
- R_RESP  out  2  OKAY 00 / SLVERR 10, constant for the burst.
- R_LAST  out  1  high on the final beat (beat count == AR_LEN).
- R_VALID out 1; R_READY in 1: read data handshake.
- AW_READY out 1; AW_VALID in 1; AW_ADDR in AXI_ADDR_WIDTH; AW_LEN in 8; AW_SIZE in 3; AW_BURST in 2: write address channel.
- W_READY out 1; W_DATA in AXI_DATA_WIDTH; W_STRB in AXI_DATA_WIDTH/8; W_LAST in 1; W_VALID in 1: write data channel.
- B_RESP out 2; B_VALID out 1; B_READY in 1: write response channel.
## Operation
- States: IDLE, READ, WRITE, RESP. IDLE drives AR_READY=1 and AW_READY=1; all other states drive both 0.
- Address acceptance:
  - IDLE + AR handshake -> READ; IDLE + AW handshake -> WRITE.
  - Both valid in the same cycle: read wins, AW stays pending (AW_READY is 0 in READ).
  - On acceptance, latch addr, len, size and burst; clear the beat counter.
- Error check at acceptance; error if any of:
  - size > log2(AXI_DATA_WIDTH/8);
  - burst == 2'b11;
  - WRAP with len not in {1,3,7,15};
  - WRAP with address not aligned to (1<<size).
- Error-burst handling:
  - Read: all beats still returned, R_DATA=0, R_RESP=10.
  - Write: all beats still accepted, o_wr_en held 0, B_RESP=10.
- READ: R_VALID=1. Each R handshake increments the counter and advances the address. Handshake with R_LAST -> IDLE.
- WRITE: W_READY=1. The burst ends on the handshake where counter == len, then -> RESP. W_LAST asserted on any other beat, or absent on the final beat, sets SLVERR. Writes of correctly sized beats still occur.
- RESP: B_VALID=1 until B_READY, then -> IDLE.
- Next address, step = 1<<size:
  - FIXED: unchanged.
  - INCR: addr + step, full-width wrap-around at 2^AXI_ADDR_WIDTH.
  - WRAP: boundary = (len+1)*step; next = (addr & ~(boundary-1)) | ((addr+step) & (boundary-1)).
- Reset: from any state, even mid-burst, go to IDLE immediately. The in-flight burst is dropped with no response.
## Timing
- Reset values: all outputs 0, B_RESP=00, R_RESP=00.
- Read: AR accepted at edge N; R_VALID from cycle N+1. With R_READY held high, one beat per cycle; a burst of len+1 beats completes at N+1+len. AR_READY returns the cycle after the R_LAST handshake.
- R_VALID, R_DATA, R_LAST and R_RESP are stable while R_READY is low.
- Write: W_READY from N+1. B_VALID appears the cycle after the last W handshake.
- o_addr is valid in the same cycle as its beat. The memory samples o_wr_en/o_addr/o_wr_strb at the handshake edge.
## Structure
- Package axi_pkg holds:
  - t_burst enum (FIXED 00, INCR 01, WRAP 10);
  - RESP_OKAY and RESP_SLVERR constants;
  - t_state enum.
- Sub-module axi_addr_gen: combinational next-address calculator (addr, size, len, burst -> next addr), shared by the read and write paths.
## Test plan
- INCR read: AR_ADDR=0x100, LEN=3, SIZE=2, R_READY=1 -> 4 beats at 0x100,0x104,0x108,0x10C; R_LAST only on beat 4; RESP=00.
- WRAP read: AR_ADDR=0x38, LEN=3, SIZE=2 -> addresses 0x38,0x3C,0x30,0x34.
- FIXED write: AW_ADDR=0x20, LEN=1, W_STRB=4'b0011 -> two o_wr_en pulses at 0x20 with strb 0011; B_RESP=00 held until B_READY.
- Back-pressure: R_READY toggling 1,0,0,1 -> R_DATA/o_addr frozen during the low cycles; beat count unchanged.
- Errors: read with SIZE=3 on 32-bit data -> beats of zero data, R_RESP=10. Write with early W_LAST -> B_RESP=10.
- Simultaneous AR/AW in IDLE -> read burst first, write accepted afterward; arst pulse mid-write -> outputs back to reset values the same cycle.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared types and helpers for the AXI4 burst slave.
// Burst encodings, response codes, FSM states, burst legality check.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } t_burst;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } t_state;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic burst_err(
    input logic [6:0] addr_lo,
    input logic [7:0] len,
    input logic [2:0] size,
    input logic [1:0] burst,
    input logic [2:0] max_size
  );
    logic       bad;
    logic [6:0] mask;
    mask = (7'd1 << size) - 7'd1;
    bad  = (size > max_size) || (burst == 2'b11);
    if (burst == WRAP) begin
      bad = bad || !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
      bad = bad || ((addr_lo & mask) != 7'd0);
    end
    return bad;
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Next beat address for FIXED, INCR and WRAP bursts.
// Purely combinational; shared by the read and write paths.
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int AW = 64
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] step;
  logic [AW-1:0] bnd;
  logic [AW-1:0] mask;
  logic [AW-1:0] inc;

  always_comb begin
    step = AW'(1) << size;
    bnd  = AW'({1'b0, len} + 9'd1) << size;
    mask = bnd - AW'(1);
    inc  = addr + step;
    unique case (burst)
      FIXED:   next_addr = addr;
      INCR:    next_addr = inc;
      WRAP:    next_addr = (addr & ~mask) | (inc & mask);
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_slave.sv
// AXI4 burst slave in front of an async-read, sync-write word memory.
// One burst at a time; reads win over writes when both arrive together.
module axi_burst_slave
  import axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        arst,
  output logic [AXI_ADDR_WIDTH-1:0]   o_addr,
  output logic                        o_rd_en,
  input  logic [AXI_DATA_WIDTH-1:0]   i_rd_data,
  output logic                        o_wr_en,
  output logic [AXI_DATA_WIDTH-1:0]   o_wr_data,
  output logic [AXI_DATA_WIDTH/8-1:0] o_wr_strb,
  output logic                        AR_READY,
  input  logic                        AR_VALID,
  input  logic [AXI_ADDR_WIDTH-1:0]   AR_ADDR,
  input  logic [7:0]                  AR_LEN,
  input  logic [2:0]                  AR_SIZE,
  input  logic [1:0]                  AR_BURST,
  output logic [AXI_DATA_WIDTH-1:0]   R_DATA,
  output logic [1:0]                  R_RESP,
  output logic                        R_LAST,
  output logic                        R_VALID,
  input  logic                        R_READY,
  output logic                        AW_READY,
  input  logic                        AW_VALID,
  input  logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
  input  logic [7:0]                  AW_LEN,
  input  logic [2:0]                  AW_SIZE,
  input  logic [1:0]                  AW_BURST,
  output logic                        W_READY,
  input  logic [AXI_DATA_WIDTH-1:0]   W_DATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
  input  logic                        W_LAST,
  input  logic                        W_VALID,
  output logic [1:0]                  B_RESP,
  output logic                        B_VALID,
  input  logic                        B_READY
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam logic [2:0] MAX_SIZE =
    3'($clog2(AXI_DATA_WIDTH / 8));

  t_state        state;
  t_state        state_nx;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_nx;
  logic [7:0]    len_q;
  logic [7:0]    cnt_q;
  logic [2:0]    size_q;
  logic [1:0]    burst_q;
  logic          err_q;
  logic          wl_err_q;

  logic ar_hs;
  logic aw_hs;
  logic r_hs;
  logic w_hs;
  logic beat;
  logic last;

  assign ar_hs = (state == IDLE) && AR_VALID;
  assign aw_hs = (state == IDLE) && AW_VALID && !AR_VALID;
  assign r_hs  = (state == READ) && R_READY;
  assign w_hs  = (state == WRITE) && W_VALID;
  assign beat  = r_hs || w_hs;
  assign last  = (cnt_q == len_q);

  axi_addr_gen #(.AW(AW)) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (addr_nx)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (AR_VALID)      state_nx = READ;
        else if (AW_VALID) state_nx = WRITE;
      end
      READ:    if (r_hs && last) state_nx = IDLE;
      WRITE:   if (w_hs && last) state_nx = RESP;
      RESP:    if (B_READY)      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Ready lines drop while reset is held so every output reads 0.
  always_comb begin
    AR_READY  = (state == IDLE) && !arst;
    AW_READY  = (state == IDLE) && !arst;
    R_VALID   = (state == READ);
    o_rd_en   = R_VALID;
    R_LAST    = R_VALID && last;
    R_DATA    = (R_VALID && !err_q) ? i_rd_data : '0;
    R_RESP    = (R_VALID && err_q) ? RESP_SLVERR : RESP_OKAY;
    W_READY   = (state == WRITE);
    o_wr_en   = w_hs && !err_q;
    o_wr_data = W_READY ? W_DATA : '0;
    o_wr_strb = W_READY ? W_STRB : '0;
    B_VALID   = (state == RESP);
    B_RESP    = (B_VALID && (err_q || wl_err_q)) ?
                RESP_SLVERR : RESP_OKAY;
    o_addr    = addr_q;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      wl_err_q <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (1'b1)
        ar_hs: begin
          addr_q   <= AR_ADDR;
          len_q    <= AR_LEN;
          size_q   <= AR_SIZE;
          burst_q  <= AR_BURST;
          cnt_q    <= '0;
          wl_err_q <= 1'b0;
          err_q    <= burst_err(AR_ADDR[6:0], AR_LEN,
                                AR_SIZE, AR_BURST, MAX_SIZE);
        end
        aw_hs: begin
          addr_q   <= AW_ADDR;
          len_q    <= AW_LEN;
          size_q   <= AW_SIZE;
          burst_q  <= AW_BURST;
          cnt_q    <= '0;
          wl_err_q <= 1'b0;
          err_q    <= burst_err(AW_ADDR[6:0], AW_LEN,
                                AW_SIZE, AW_BURST, MAX_SIZE);
        end
        beat: begin
          cnt_q  <= cnt_q + 8'd1;
          addr_q <= addr_nx;
          // W_LAST must coincide exactly with the final beat.
          if (w_hs && (W_LAST != last)) wl_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_slave.sv
// Directed plus randomized bench for axi_burst_slave.
// Reference memory and burst address rules are modelled arithmetically.
module tb_axi_burst_slave;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          arst;
  logic [AW-1:0] o_addr;
  logic          o_rd_en;
  logic [DW-1:0] i_rd_data;
  logic          o_wr_en;
  logic [DW-1:0] o_wr_data;
  logic [SW-1:0] o_wr_strb;
  logic          AR_READY;
  logic          AR_VALID;
  logic [AW-1:0] AR_ADDR;
  logic [7:0]    AR_LEN;
  logic [2:0]    AR_SIZE;
  logic [1:0]    AR_BURST;
  logic [DW-1:0] R_DATA;
  logic [1:0]    R_RESP;
  logic          R_LAST;
  logic          R_VALID;
  logic          R_READY;
  logic          AW_READY;
  logic          AW_VALID;
  logic [AW-1:0] AW_ADDR;
  logic [7:0]    AW_LEN;
  logic [2:0]    AW_SIZE;
  logic [1:0]    AW_BURST;
  logic          W_READY;
  logic [DW-1:0] W_DATA;
  logic [SW-1:0] W_STRB;
  logic          W_LAST;
  logic          W_VALID;
  logic [1:0]    B_RESP;
  logic          B_VALID;
  logic          B_READY;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  axi_burst_slave #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .o_addr    (o_addr),
    .o_rd_en   (o_rd_en),
    .i_rd_data (i_rd_data),
    .o_wr_en   (o_wr_en),
    .o_wr_data (o_wr_data),
    .o_wr_strb (o_wr_strb),
    .AR_READY  (AR_READY),
    .AR_VALID  (AR_VALID),
    .AR_ADDR   (AR_ADDR),
    .AR_LEN    (AR_LEN),
    .AR_SIZE   (AR_SIZE),
    .AR_BURST  (AR_BURST),
    .R_DATA    (R_DATA),
    .R_RESP    (R_RESP),
    .R_LAST    (R_LAST),
    .R_VALID   (R_VALID),
    .R_READY   (R_READY),
    .AW_READY  (AW_READY),
    .AW_VALID  (AW_VALID),
    .AW_ADDR   (AW_ADDR),
    .AW_LEN    (AW_LEN),
    .AW_SIZE   (AW_SIZE),
    .AW_BURST  (AW_BURST),
    .W_READY   (W_READY),
    .W_DATA    (W_DATA),
    .W_STRB    (W_STRB),
    .W_LAST    (W_LAST),
    .W_VALID   (W_VALID),
    .B_RESP    (B_RESP),
    .B_VALID   (B_VALID),
    .B_READY   (B_READY)
  );

  function automatic logic [DW-1:0] init_val(input int k);
    return 32'(k) * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  // Environment memory: async read, byte-strobed write at the edge.
  assign i_rd_data = mem[o_addr[9:2]];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 256; k++) mem[k] <= init_val(k);
    end else if (o_wr_en) begin
      for (int b = 0; b < SW; b++)
        if (o_wr_strb[b])
          mem[o_addr[9:2]][b*8 +: 8] <= o_wr_data[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_err(input logic [63:0] a,
    input int len, input int size, input int burst);
    logic bad;
    bad = (size > 2) || (burst == 3);
    if (burst == 2)
      bad = bad || !(len == 1 || len == 3 || len == 7 || len == 15)
                || ((a % (64'd1 << size)) != 0);
    return bad;
  endfunction

  // Address of beat i, computed directly from the burst start.
  function automatic logic [63:0] beat_addr(input logic [63:0] a,
    input int len, input int size, input int burst, input int i);
    logic [63:0] step, bnd, base;
    step = 64'd1 << size;
    if (burst == 0) return a;
    if (burst == 1) return a + 64'(i) * step;
    bnd  = 64'(len + 1) * step;
    base = a - (a % bnd);
    return base + ((a - base + 64'(i) * step) % bnd);
  endfunction

  task automatic rd(input logic [63:0] a, input int len,
                    input int size, input int burst,
                    input logic [31:0] pat, input string tag);
    logic        err;
    logic [63:0] ea;
    logic [31:0] ed;
    int          i;
    int          cyc;
    err      = model_err(a, len, size, burst);
    AR_ADDR  = a;
    AR_LEN   = 8'(len);
    AR_SIZE  = 3'(size);
    AR_BURST = 2'(burst);
    AR_VALID = 1'b1;
    chk({tag, "_arready"}, AR_READY, 1);
    @(negedge clk);
    AR_VALID = 1'b0;
    i   = 0;
    cyc = 0;
    while (i <= len) begin
      ea = beat_addr(a, len, size, burst, i);
      ed = err ? 32'd0 : ref_mem[ea[9:2]];
      chk({tag, "_rvalid"}, R_VALID, 1);
      chk({tag, "_rden"}, o_rd_en, 1);
      chk({tag, "_rlast"}, R_LAST, i == len);
      chk({tag, "_rresp"}, R_RESP, err ? 2'b10 : 2'b00);
      chk({tag, "_rdata"}, R_DATA, ed);
      if (!err) chk({tag, "_raddr"}, o_addr, ea);
      if (cyc == 0) chk({tag, "_awready"}, AW_READY, 0);
      R_READY = pat[cyc % 32];
      if (R_READY) i++;
      cyc++;
      if (cyc > 1200) begin
        checks++;
        errors++;
        $error("FAIL %s_timeout got=%0d exp<=1200", tag, cyc);
        break;
      end
      @(negedge clk);
    end
    R_READY = 1'b0;
    chk({tag, "_done_rvalid"}, R_VALID, 0);
    chk({tag, "_done_arready"}, AR_READY, 1);
    if (pat == 32'hFFFF_FFFF)
      chk({tag, "_cycles"}, cyc, len + 1);
  endtask

  task automatic wr(input logic [63:0] a, input int len,
                    input int size, input int burst,
                    input int strb, input bit early,
                    input int abort_at, input string tag);
    logic          err;
    logic          bad;
    logic          wv;
    logic [63:0]   ea;
    logic [SW-1:0] st;
    logic [DW-1:0] d;
    int            i;
    int            cyc;
    err      = model_err(a, len, size, burst);
    bad      = err || (early && len > 0);
    AW_ADDR  = a;
    AW_LEN   = 8'(len);
    AW_SIZE  = 3'(size);
    AW_BURST = 2'(burst);
    AW_VALID = 1'b1;
    chk({tag, "_awready"}, AW_READY, 1);
    @(negedge clk);
    AW_VALID = 1'b0;
    i   = 0;
    cyc = 0;
    while (i <= len) begin
      chk({tag, "_wready"}, W_READY, 1);
      if (abort_at == i) begin
        arst    = 1'b1;
        W_VALID = 1'b0;
        #1;
        chk({tag, "_rst_wready"}, W_READY, 0);
        chk({tag, "_rst_wen"}, o_wr_en, 0);
        chk({tag, "_rst_bvalid"}, B_VALID, 0);
        chk({tag, "_rst_arready"}, AR_READY, 0);
        chk({tag, "_rst_awready"}, AW_READY, 0);
        chk({tag, "_rst_addr"}, o_addr, 0);
        chk({tag, "_rst_bresp"}, B_RESP, 0);
        @(negedge clk);
        arst = 1'b0;
        #1;
        chk({tag, "_post_arready"}, AR_READY, 1);
        chk({tag, "_post_bvalid"}, B_VALID, 0);
        return;
      end
      wv = ($urandom_range(0, 3) != 0);
      ea = beat_addr(a, len, size, burst, i);
      st = (strb < 0) ? SW'($urandom) : SW'(strb);
      d  = $urandom;
      W_VALID = wv;
      W_DATA  = d;
      W_STRB  = st;
      W_LAST  = early ? (i == 0) : (i == len);
      #1;
      chk({tag, "_wen"}, o_wr_en, wv && !err);
      if (wv && !err) begin
        chk({tag, "_waddr"}, o_addr, ea);
        chk({tag, "_wstrb"}, o_wr_strb, st);
        chk({tag, "_wdata"}, o_wr_data, d);
        for (int b = 0; b < SW; b++)
          if (st[b]) ref_mem[ea[9:2]][b*8 +: 8] = d[b*8 +: 8];
      end
      if (wv) i++;
      cyc++;
      if (cyc > 1200) begin
        checks++;
        errors++;
        $error("FAIL %s_timeout got=%0d exp<=1200", tag, cyc);
        break;
      end
      @(negedge clk);
    end
    W_VALID = 1'b0;
    W_LAST  = 1'b0;
    chk({tag, "_bvalid"}, B_VALID, 1);
    chk({tag, "_bresp"}, B_RESP, bad ? 2'b10 : 2'b00);
    @(negedge clk);
    chk({tag, "_bhold"}, B_VALID, 1);
    chk({tag, "_bresp_hold"}, B_RESP, bad ? 2'b10 : 2'b00);
    B_READY = 1'b1;
    @(negedge clk);
    B_READY = 1'b0;
    chk({tag, "_bdone"}, B_VALID, 0);
    chk({tag, "_idle_awready"}, AW_READY, 1);
  endtask

  initial begin
    int lens [4];
    int bu;
    int sz;
    int ln;
    logic [63:0] a;
    lens = '{1, 3, 7, 15};
    arst = 1'b1;
    AR_VALID = 0; AR_ADDR = 0; AR_LEN = 0; AR_SIZE = 0; AR_BURST = 0;
    AW_VALID = 0; AW_ADDR = 0; AW_LEN = 0; AW_SIZE = 0; AW_BURST = 0;
    W_VALID = 0; W_DATA = 0; W_STRB = 0; W_LAST = 0;
    R_READY = 0; B_READY = 0;
    for (int k = 0; k < 256; k++) ref_mem[k] = init_val(k);
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_arready", AR_READY, 0);
    chk("rst_awready", AW_READY, 0);
    chk("rst_rvalid", R_VALID, 0);
    chk("rst_wready", W_READY, 0);
    chk("rst_bvalid", B_VALID, 0);
    chk("rst_rresp", R_RESP, 0);
    chk("rst_bresp", B_RESP, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_rdata", R_DATA, 0);
    arst = 1'b0;
    @(negedge clk);
    chk("rel_arready", AR_READY, 1);

    rd(64'h100, 3, 2, 1, 32'hFFFF_FFFF, "incr_rd");
    rd(64'h38, 3, 2, 2, 32'hFFFF_FFFF, "wrap_rd");
    wr(64'h20, 1, 2, 0, 4'b0011, 1'b0, -1, "fixed_wr");
    rd(64'h20, 0, 2, 1, 32'hFFFF_FFFF, "fixed_rb");
    rd(64'h200, 3, 2, 1, 32'hFFFF_FFF9, "bp_rd");
    rd(64'h40, 2, 3, 1, 32'hFFFF_FFFF, "err_rd");
    wr(64'h80, 3, 2, 1, -1, 1'b1, -1, "early_wr");
    rd(64'h80, 3, 2, 1, 32'hFFFF_FFFF, "early_rb");

    AW_ADDR = 64'h300; AW_LEN = 8'd2; AW_SIZE = 3'd2;
    AW_BURST = 2'd1; AW_VALID = 1'b1;
    rd(64'h180, 1, 2, 1, 32'hFFFF_FFFF, "sim_rd");
    wr(64'h300, 2, 2, 1, -1, 1'b0, -1, "sim_wr");
    rd(64'h300, 2, 2, 1, 32'hFFFF_FFFF, "sim_rb");

    wr(64'h3C0, 5, 2, 1, -1, 1'b0, 2, "abort_wr");
    rd(64'h3C0, 5, 2, 1, 32'hFFFF_FFFF, "abort_rb");

    for (int t = 0; t < 30; t++) begin
      bu = $urandom_range(0, 9);
      bu = (bu < 3) ? 0 : (bu < 6) ? 1 : (bu < 9) ? 2 : 3;
      sz = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      ln = $urandom_range(0, 7);
      if (bu == 2 && $urandom_range(0, 4) != 0)
        ln = lens[$urandom_range(0, 3)];
      a = 64'($urandom_range(0, 1023));
      if (bu == 2 && $urandom_range(0, 4) != 0)
        a = a & ~((64'd1 << sz) - 64'd1);
      if ($urandom_range(0, 1) == 1)
        rd(a, ln, sz, bu, $urandom | 32'h1, "rnd_rd");
      else
        wr(a, ln, sz, bu, -1, ($urandom_range(0, 5) == 0), -1,
           "rnd_wr");
    end

    for (int k = 0; k < 256; k += 16)
      rd(64'(k * 4), 15, 2, 1, 32'hFFFF_FFFF, "sweep_rb");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
